// File: rtl/tpu_matmul_engine.sv
// N x N signed matrix-multiply engine: operand and accumulator storage, an N-cycle
// fully parallel multiply-accumulate, and a valid/ready saturated result stream.

module tpu_mac_cell #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         en_i,
    input  logic                         restart_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic        [ACC_WIDTH-1:0]  c_o
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    base;
    logic signed [ACC_WIDTH-1:0]    c_q;

    assign prod = a_i * b_i;
    assign base = restart_i ? '0 : c_q;
    assign c_o  = c_q;

    // Sign-extended product; the sum simply wraps at ACC_WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       c_q <= '0;
        else if (clear_i) c_q <= '0;
        else if (en_i)    c_q <= base + ACC_WIDTH'(prod);
    end
endmodule

module tpu_matmul_engine #(
    parameter  int N          = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int ACC_WIDTH  = 16,
    parameter  int OUT_WIDTH  = 8,
    localparam int IDX_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [IDX_W-1:0]      cmd_row,
    input  logic [IDX_W-1:0]      cmd_col,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [OUT_WIDTH-1:0]  res_data,
    output logic                  res_last
);
    localparam logic [2:0] OP_LOAD_A = 3'b001, OP_LOAD_B = 3'b010, OP_MATMUL = 3'b011,
                           OP_MACC   = 3'b100, OP_READ   = 3'b101, OP_STREAM = 3'b110,
                           OP_CLEAR  = 3'b111;
    localparam logic [IDX_W:0]   NUM   = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LASTI = IDX_W'(N-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

    state_t state_q, state_d;
    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0]  c_w;
    logic [IDX_W-1:0] k_q, k_d, row_q, row_d, col_q, col_d;
    logic acc_q, acc_d, single_q, single_d, oor_q, oor_d, done_q, done_d, live_q;
    logic accept, in_range, mac_en, mac_restart, clear_c;
    logic signed [ACC_WIDTH-1:0] c_sel;
    logic [OUT_WIDTH-1:0] sat_val;

    // live_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready   = live_q && (state_q == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign in_range    = ({1'b0, cmd_row} < NUM) && ({1'b0, cmd_col} < NUM);
    assign mac_en      = (state_q == COMPUTE);
    assign mac_restart = (k_q == '0) && !acc_q;
    assign clear_c     = accept && (cmd_op == OP_CLEAR);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign res_valid   = (state_q == OUT);
    assign res_last    = res_valid && (single_q || (row_q == LASTI && col_q == LASTI));
    assign res_data    = (res_valid && !oor_q) ? sat_val : '0;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            tpu_mac_cell #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear_i   (clear_c),
                .en_i      (mac_en),
                .restart_i (mac_restart),
                .a_i       (a_q[i][k_q]),
                .b_i       (b_q[k_q][j]),
                .c_o       (c_w[i][j])
            );
        end
    end

    always_comb begin
        c_sel = c_w[row_q][col_q];
        if (c_sel > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
        else if (c_sel < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
        else                      sat_val = c_sel[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        acc_d    = acc_q;
        row_d    = row_q;
        col_d    = col_q;
        single_d = single_q;
        oor_d    = oor_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                case (cmd_op)
                    OP_LOAD_A: if (in_range) a_d[cmd_row][cmd_col] = cmd_data;
                    OP_LOAD_B: if (in_range) b_d[cmd_row][cmd_col] = cmd_data;
                    OP_MATMUL, OP_MACC: begin
                        state_d = COMPUTE;
                        k_d     = '0;
                        acc_d   = (cmd_op == OP_MACC);
                    end
                    OP_READ: begin
                        // An out-of-range read parks on (0,0) and forces a zero result.
                        state_d  = OUT;
                        single_d = 1'b1;
                        oor_d    = !in_range;
                        row_d    = in_range ? cmd_row : '0;
                        col_d    = in_range ? cmd_col : '0;
                    end
                    OP_STREAM: begin
                        state_d  = OUT;
                        single_d = 1'b0;
                        oor_d    = 1'b0;
                        row_d    = '0;
                        col_d    = '0;
                    end
                    default: ;
                endcase
            end
            COMPUTE: begin
                k_d = k_q + 1'b1;
                if (k_q == LASTI) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            OUT: if (res_ready) begin
                if (res_last) begin
                    state_d = IDLE;
                end else if (col_q == LASTI) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            acc_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            single_q <= 1'b0;
            oor_q    <= 1'b0;
            done_q   <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            row_q    <= row_d;
            col_q    <= col_d;
            single_q <= single_d;
            oor_q    <= oor_d;
            done_q   <= done_d;
            live_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tpu_matmul_engine.sv
// Randomized bench for tpu_matmul_engine: N=4 and N=3 instances share a command bus and
// are checked against a whole-matrix arithmetic reference model.

module tb_tpu_matmul_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [1:0] cmd_row, cmd_col;
    logic [7:0] cmd_data;
    logic       res_ready;

    logic       rdy4, busy4, done4, rv4, rl4, rdy3, busy3, done3, rv3, rl3;
    logic [7:0] rd4, rd3;
    logic       cmd_ready, busy, done, res_valid, res_last;
    logic [7:0] res_data;

    int n_chk = 0;
    int n_fail = 0;
    int ma[2][4][4], mb[2][4][4], mc[2][4][4];
    int exp_q[$];

    always #5 clk = ~clk;

    tpu_matmul_engine #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy4),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
        .busy(busy4), .done(done4), .res_valid(rv4), .res_ready(res_ready && !sel),
        .res_data(rd4), .res_last(rl4)
    );

    tpu_matmul_engine #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && sel), .cmd_ready(rdy3),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
        .busy(busy3), .done(done3), .res_valid(rv3), .res_ready(res_ready && sel),
        .res_data(rd3), .res_last(rl3)
    );

    assign cmd_ready = sel ? rdy3 : rdy4;
    assign busy      = sel ? busy3 : busy4;
    assign done      = sel ? done3 : done4;
    assign res_valid = sel ? rv3 : rv4;
    assign res_last  = sel ? rl3 : rl4;
    assign res_data  = sel ? rd3 : rd4;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap16(input longint v);
        longint w;
        w = v & 64'hFFFF;
        if (w >= 32768) w -= 65536;
        return int'(w);
    endfunction

    function automatic int sat8(input int v);
        return (v > 127) ? 127 : (v < -128) ? -128 : v;
    endfunction

    function automatic int dim();
        return sel ? 3 : 4;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[s][i][j] = 0; mb[s][i][j] = 0; mc[s][i][j] = 0;
                end
    endtask

    // Reference: whole matrix product with a single wrap, then saturation on readout.
    task automatic model_apply(input int op, input int row, input int col, input int data);
        int s, n;
        longint acc;
        s = sel ? 1 : 0;
        n = dim();
        case (op)
            1: if (row < n && col < n) ma[s][row][col] = data;
            2: if (row < n && col < n) mb[s][row][col] = data;
            3, 4: begin
                int nc[4][4];
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n; j++) begin
                        acc = (op == 4) ? longint'(mc[s][i][j]) : 0;
                        for (int k = 0; k < n; k++) acc += longint'(ma[s][i][k] * mb[s][k][j]);
                        nc[i][j] = wrap16(acc);
                    end
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n; j++) mc[s][i][j] = nc[i][j];
            end
            5: exp_q.push_back((row < n && col < n) ? sat8(mc[s][row][col]) : 0);
            6: for (int i = 0; i < n; i++)
                   for (int j = 0; j < n; j++) exp_q.push_back(sat8(mc[s][i][j]));
            7: for (int i = 0; i < 4; i++)
                   for (int j = 0; j < 4; j++) mc[s][i][j] = 0;
            default: ;
        endcase
    endtask

    task automatic send(input int op, input int row, input int col, input int data);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_row   = 2'(row);
        cmd_col   = 2'(col);
        cmd_data  = 8'(data);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_apply(op, row, col, data);
    endtask

    task automatic run_matmul(input bit acc);
        send(acc ? 4 : 3, 0, 0, 0);
        chk("busy_compute", busy, 1);
        for (int c = 1; c <= dim() + 1; c++) begin
            @(posedge clk);
            #1;
            chk("done_pulse", done, (c == dim()) ? 1 : 0);
            chk("ready_compute", cmd_ready, (c >= dim()) ? 1 : 0);
            chk("valid_compute", res_valid, 0);
        end
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic collect(input int mode);
        int idx, cyc, nexp, held_d, held_l;
        bit stalled;
        nexp = exp_q.size();
        idx = 0; cyc = 0; stalled = 0; held_d = 0; held_l = 0;
        while (idx < nexp && cyc < 400) begin
            @(negedge clk);
            case (mode)
                0:       res_ready = 1'b1;
                1:       res_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            chk("res_valid_on", res_valid, 1);
            chk("ready_out", cmd_ready, 0);
            if (stalled) begin
                chk("hold_data", $signed(res_data), held_d);
                chk("hold_last", res_last, held_l);
            end
            held_d  = $signed(res_data);
            held_l  = res_last;
            stalled = !res_ready;
            if (res_ready) begin
                chk("res_data", $signed(res_data), exp_q[idx]);
                chk("res_last", res_last, (idx == nexp - 1) ? 1 : 0);
                idx++;
            end
            cyc++;
        end
        if (idx < nexp) chk("stream_timeout", idx, nexp);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_off", res_valid, 0);
        chk("res_data_idle", res_data, 0);
        chk("ready_after_out", cmd_ready, 1);
        exp_q.delete();
    endtask

    task automatic rand_loads();
        for (int i = 0; i < dim(); i++)
            for (int j = 0; j < dim(); j++) begin
                send(1, i, j, int'($urandom_range(0, 255)) - 128);
                send(2, i, j, int'($urandom_range(0, 255)) - 128);
            end
    endtask

    initial begin
        sel = 0; cmd_valid = 0; cmd_op = 0; cmd_row = 0; cmd_col = 0; cmd_data = 0;
        res_ready = 0; rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_last", res_last, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("ready_after_rst", cmd_ready, 1);

        // Identity multiply
        for (int i = 0; i < 4; i++) begin
            send(1, i, i, 1);
            for (int j = 0; j < 4; j++) send(2, i, j, 4 * i + j);
        end
        run_matmul(0);
        send(6, 0, 0, 0);
        collect(0);

        // Saturation and accumulate wrap
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                send(1, i, j, 0);
                send(2, i, j, 0);
            end
        send(1, 0, 0, 127);
        send(2, 0, 0, 127);
        run_matmul(0);
        send(5, 0, 0, 0);
        collect(0);
        send(1, 0, 0, -128);
        run_matmul(0);
        send(5, 0, 0, 0);
        collect(0);
        send(1, 0, 0, 127);
        run_matmul(0);
        run_matmul(1);
        run_matmul(1);
        send(5, 0, 0, 0);
        collect(1);

        // Random matrices, mixed MATMUL/MATMUL_ACC, backpressured streams
        repeat (4) begin
            rand_loads();
            run_matmul(1'($urandom_range(0, 1)));
            send(0, 0, 0, 0);
            run_matmul(1'($urandom_range(0, 1)));
            send(6, 0, 0, 0);
            collect(1);
            send(5, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            collect(2);
        end

        // Reset in the middle of a stream
        send(6, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        @(negedge clk);
        rst_n = 0;
        res_ready = 0;
        #1;
        chk("midrst_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("midrst_ready_after", cmd_ready, 1);
        send(5, 2, 3, 0);
        collect(0);

        // N=3: out-of-range load ignored, CLEAR, out-of-range read
        sel = 1;
        rand_loads();
        send(1, 3, 1, 55);
        send(1, 1, 3, -7);
        send(2, 3, 3, 99);
        run_matmul(0);
        send(6, 0, 0, 0);
        collect(1);
        send(7, 0, 0, 0);
        send(6, 0, 0, 0);
        collect(0);
        rand_loads();
        run_matmul(0);
        send(5, 3, 0, 0);
        collect(0);
        send(5, 0, 3, 0);
        collect(2);
        send(5, 2, 2, 0);
        collect(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
